// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: two execute-pipe producers plus the
// register-file write port, retire count and source tag.
interface writeback_arbiter_if #(
  parameter int p_data_bits = 32,
  parameter int p_cnt_bits  = 32
);
  logic                   X0_val;
  logic                   X0_rdy;
  logic [4:0]             X0_waddr;
  logic [p_data_bits-1:0] X0_wdata;
  logic                   X0_wen;

  logic                   X1_val;
  logic                   X1_rdy;
  logic [4:0]             X1_waddr;
  logic [p_data_bits-1:0] X1_wdata;
  logic                   X1_wen;

  logic                   rf_wen;
  logic [4:0]             rf_waddr;
  logic [p_data_bits-1:0] rf_wdata;
  logic [p_cnt_bits-1:0]  retire_cnt;
  logic                   last_src;

  modport master (
    output X0_val, X0_waddr, X0_wdata, X0_wen,
    output X1_val, X1_waddr, X1_wdata, X1_wen,
    input  X0_rdy, X1_rdy,
    input  rf_wen, rf_waddr, rf_wdata,
    input  retire_cnt, last_src
  );

  modport slave (
    input  X0_val, X0_waddr, X0_wdata, X0_wen,
    input  X1_val, X1_waddr, X1_wdata, X1_wen,
    output X0_rdy, X1_rdy,
    output rf_wen, rf_waddr, rf_wdata,
    output retire_cnt, last_src
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: merges two execute pipes
// into one registered register-file write port.
module writeback_arbiter #(
  parameter int p_data_bits = 32,
  parameter int p_cnt_bits  = 32
) (
  input  logic               clk,
  input  logic               rst,
  writeback_arbiter_if.slave bus
);

  logic                   grant0;
  logic                   grant1;

  logic                   ptr_q, ptr_d;
  logic                   rf_wen_q, rf_wen_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [p_data_bits-1:0] rf_wdata_q, rf_wdata_d;
  logic                   last_src_q, last_src_d;
  logic [p_cnt_bits-1:0]  cnt_q, cnt_d;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant0 = bus.X0_val & (~bus.X1_val | ~ptr_q);
    grant1 = bus.X1_val & (~bus.X0_val | ptr_q);
  end

  assign bus.X0_rdy = rst & grant0;
  assign bus.X1_rdy = rst & grant1;

  always_comb begin
    ptr_d      = ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    last_src_d = last_src_q;
    cnt_d      = cnt_q;
    unique case (1'b1)
      grant0: begin
        ptr_d      = 1'b1;
        rf_wen_d   = bus.X0_wen & (|bus.X0_waddr);
        rf_waddr_d = bus.X0_waddr;
        rf_wdata_d = bus.X0_wdata;
        last_src_d = 1'b0;
        cnt_d      = cnt_q + 1'b1;
      end
      grant1: begin
        ptr_d      = 1'b0;
        rf_wen_d   = bus.X1_wen & (|bus.X1_waddr);
        rf_waddr_d = bus.X1_waddr;
        rf_wdata_d = bus.X1_wdata;
        last_src_d = 1'b1;
        cnt_d      = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      last_src_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      last_src_q <= last_src_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.last_src   = last_src_q;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vectors plus queue-driven traffic for the
// writeback arbiter, using a 4-bit retire counter.
module tb_writeback_arbiter;

  localparam int P_D = 32;
  localparam int P_C = 4;

  logic clk;
  logic rst;

  writeback_arbiter_if #(
    .p_data_bits(P_D),
    .p_cnt_bits (P_C)
  ) bus ();

  writeback_arbiter #(
    .p_data_bits(P_D),
    .p_cnt_bits (P_C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        w;
  } msg_t;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        w0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        w1;
    logic        r0;
    logic        r1;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
    logic [3:0]  cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  msg_t       q0[$];
  msg_t       q1[$];
  logic       exp_ptr;
  logic [3:0] exp_cnt;
  vec_t       tbl[9];
  int         idle;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.X0_val   = 1'b0;
    bus.X0_waddr = '0;
    bus.X0_wdata = '0;
    bus.X0_wen   = 1'b0;
    bus.X1_val   = 1'b0;
    bus.X1_waddr = '0;
    bus.X1_wdata = '0;
    bus.X1_wen   = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    exp_ptr = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic chk_rf(input string tag, input msg_t m,
                        input logic src);
    chk({tag, "_wen"}, 64'(bus.rf_wen),
        64'(m.w && (m.a != 5'd0)));
    chk({tag, "_addr"}, 64'(bus.rf_waddr), 64'(m.a));
    chk({tag, "_data"}, 64'(bus.rf_wdata), 64'(m.d));
    chk({tag, "_src"}, 64'(bus.last_src), 64'(src));
  endtask

  // Producers present queued messages and hold them until accepted.
  task automatic run_traffic(input bit rnd, input int budget,
                             output int idle_cyc);
    int   cyc;
    msg_t m0;
    msg_t m1;
    bit   g0;
    bit   g1;
    cyc      = 0;
    idle_cyc = 0;
    m0       = '0;
    m1       = '0;
    while ((q0.size() > 0 || q1.size() > 0 ||
            bus.X0_val || bus.X1_val) && cyc < budget) begin
      if (!bus.X0_val && q0.size() > 0 &&
          (!rnd || $urandom_range(0, 2) == 0)) begin
        m0 = q0.pop_front();
        bus.X0_val   = 1'b1;
        bus.X0_waddr = m0.a;
        bus.X0_wdata = m0.d;
        bus.X0_wen   = m0.w;
      end
      if (!bus.X1_val && q1.size() > 0 &&
          (!rnd || $urandom_range(0, 2) == 0)) begin
        m1 = q1.pop_front();
        bus.X1_val   = 1'b1;
        bus.X1_waddr = m1.a;
        bus.X1_wdata = m1.d;
        bus.X1_wen   = m1.w;
      end
      #1;
      g0 = bus.X0_val && (!bus.X1_val || !exp_ptr);
      g1 = bus.X1_val && (!bus.X0_val || exp_ptr);
      chk("tr_x0_rdy", 64'(bus.X0_rdy), 64'(g0));
      chk("tr_x1_rdy", 64'(bus.X1_rdy), 64'(g1));
      if (!g0 && !g1) idle_cyc++;
      @(posedge clk);
      #1;
      if (g0) begin
        exp_cnt++;
        exp_ptr = 1'b1;
        chk_rf("tr0", m0, 1'b0);
        bus.X0_val = 1'b0;
      end else if (g1) begin
        exp_cnt++;
        exp_ptr = 1'b0;
        chk_rf("tr1", m1, 1'b1);
        bus.X1_val = 1'b0;
      end else begin
        chk("tr_idle_wen", 64'(bus.rf_wen), 64'd0);
      end
      chk("tr_cnt", 64'(bus.retire_cnt), 64'(exp_cnt));
      @(negedge clk);
      cyc++;
    end
    if (q0.size() > 0 || q1.size() > 0 ||
        bus.X0_val || bus.X1_val) begin
      checks++;
      errors++;
      $display("FAIL traffic_timeout: got %0d cycles required done",
               cyc);
      clr_inputs();
    end
  endtask

  initial begin
    // {v0,a0,d0,w0, v1,a1,d1,w1, r0,r1, wen,addr,data,src,cnt}
    tbl[0] = '{1, 1, 2, 1,  0, 0, 0, 0,   1, 0, 1, 1, 2, 0, 1};
    tbl[1] = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 2, 0, 1};
    tbl[2] = '{1, 3, 12, 1, 1, 4, 144, 1, 0, 1, 1, 4, 144, 1, 2};
    tbl[3] = '{1, 3, 12, 1, 1, 6, 66, 1,  1, 0, 1, 3, 12, 0, 3};
    tbl[4] = '{0, 0, 0, 0,  1, 0, 5, 1,   0, 1, 0, 0, 5, 1, 4};
    tbl[5] = '{0, 0, 0, 0,  1, 7, 9, 0,   0, 1, 0, 7, 9, 1, 5};
    tbl[6] = '{1, 31, 32'hFFFF_FFFF, 1, 0, 0, 0, 0,
               1, 0, 1, 31, 32'hFFFF_FFFF, 0, 6};
    tbl[7] = '{1, 9, 99, 1, 0, 0, 0, 0,   1, 0, 1, 9, 99, 0, 7};
    tbl[8] = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 9, 99, 0, 7};

    clr_inputs();
    rst = 1'b0;
    exp_ptr = 1'b0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    bus.X0_val = 1'b1;
    bus.X1_val = 1'b1;
    #1;
    chk("rst_x0_rdy", 64'(bus.X0_rdy), 64'd0);
    chk("rst_x1_rdy", 64'(bus.X1_rdy), 64'd0);
    chk("rst_wen", 64'(bus.rf_wen), 64'd0);
    chk("rst_addr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_data", 64'(bus.rf_wdata), 64'd0);
    chk("rst_src", 64'(bus.last_src), 64'd0);
    chk("rst_cnt", 64'(bus.retire_cnt), 64'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      bus.X0_val   = tbl[i].v0;
      bus.X0_waddr = tbl[i].a0;
      bus.X0_wdata = tbl[i].d0;
      bus.X0_wen   = tbl[i].w0;
      bus.X1_val   = tbl[i].v1;
      bus.X1_waddr = tbl[i].a1;
      bus.X1_wdata = tbl[i].d1;
      bus.X1_wen   = tbl[i].w1;
      #1;
      chk($sformatf("v%0d_x0_rdy", i), 64'(bus.X0_rdy), 64'(tbl[i].r0));
      chk($sformatf("v%0d_x1_rdy", i), 64'(bus.X1_rdy), 64'(tbl[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wen", i), 64'(bus.rf_wen), 64'(tbl[i].wen));
      chk($sformatf("v%0d_addr", i), 64'(bus.rf_waddr), 64'(tbl[i].addr));
      chk($sformatf("v%0d_data", i), 64'(bus.rf_wdata), 64'(tbl[i].data));
      chk($sformatf("v%0d_src", i), 64'(bus.last_src), 64'(tbl[i].src));
      chk($sformatf("v%0d_cnt", i), 64'(bus.retire_cnt), 64'(tbl[i].cnt));
      @(negedge clk);
    end

    // Contention straight out of reset: pipe 0 first.
    do_reset();
    q0.push_back('{a: 5'd3, d: 32'd12, w: 1'b1});
    q1.push_back('{a: 5'd4, d: 32'd144, w: 1'b1});
    run_traffic(1'b0, 20, idle);
    chk("cont_cnt", 64'(bus.retire_cnt), 64'd2);

    // Fairness: four messages each, saturating both ports.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{a: 5'(i + 1), d: 32'(100 + i), w: 1'b1});
      q1.push_back('{a: 5'(i + 17), d: 32'(200 + i), w: 1'b1});
    end
    run_traffic(1'b0, 40, idle);
    chk("fair_idle", 64'(idle), 64'd0);
    chk("fair_cnt", 64'(bus.retire_cnt), 64'd8);

    // Reset lands between capture and register-file write.
    do_reset();
    bus.X0_val   = 1'b1;
    bus.X0_waddr = 5'd2;
    bus.X0_wdata = 32'hDEAD;
    bus.X0_wen   = 1'b1;
    #1;
    chk("mid_x0_rdy", 64'(bus.X0_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("mid_cap_wen", 64'(bus.rf_wen), 64'd1);
    bus.X0_val = 1'b0;
    bus.X1_val = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("mid_wen", 64'(bus.rf_wen), 64'd0);
    chk("mid_addr", 64'(bus.rf_waddr), 64'd0);
    chk("mid_data", 64'(bus.rf_wdata), 64'd0);
    chk("mid_src", 64'(bus.last_src), 64'd0);
    chk("mid_cnt", 64'(bus.retire_cnt), 64'd0);
    chk("mid_x1_rdy", 64'(bus.X1_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_edge_wen", 64'(bus.rf_wen), 64'd0);
    @(negedge clk);
    clr_inputs();
    rst     = 1'b1;
    exp_ptr = 1'b0;
    exp_cnt = '0;
    q1.push_back('{a: 5'd6, d: 32'h77, w: 1'b1});
    q1.push_back('{a: 5'd10, d: 32'h88, w: 1'b1});
    run_traffic(1'b0, 20, idle);
    chk("mid_after_cnt", 64'(bus.retire_cnt), 64'd2);

    // Counter wrap with random producer delays.
    do_reset();
    for (int i = 0; i < 9; i++)
      q0.push_back('{a: 5'($urandom_range(1, 31)),
                     d: $urandom, w: 1'b1});
    for (int i = 0; i < 8; i++)
      q1.push_back('{a: 5'($urandom_range(1, 31)),
                     d: $urandom, w: 1'b1});
    run_traffic(1'b1, 400, idle);
    chk("wrap_cnt", 64'(bus.retire_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
